byte_fill_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache sitting directly upstream of the byte-wide main memory. It accepts word, half-word and byte requests from the pipeline's IF/MEM stages. It serves read hits from its line array. Read misses are refilled one byte per cycle, and every store is written through as serial byte writes over the memory's `mem_vis_*` port.

---
 rtl/byte_fill_cache_pkg.sv | 31 +++
 rtl/byte_fill_cache_if.sv | 33 +++
 rtl/byte_fill_cache_line_array.sv | 42 ++++
 rtl/byte_fill_cache.sv | 208 ++++++++++++++++++++
 tb/tb_byte_fill_cache.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/byte_fill_cache_pkg.sv
// Shared constants for byte_fill_cache: memory-port codes, request size codes,
// FSM state encoding and default geometry.
package byte_fill_cache_pkg;

  localparam int DEF_ADDR_WIDTH   = 17;
  localparam int DEF_LEN          = 32;
  localparam int DEF_BYTE_SIZE    = 8;
  localparam int DEF_INDEX_WIDTH  = 4;
  localparam int DEF_OFFSET_WIDTH = 4;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] READ_DATA = 2'b01;
  localparam logic [1:0] READ_INST = 2'b10;
  localparam logic [1:0] WRITE     = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_e;

  // Size code 11 behaves as a word.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_nbytes = 3'd1;
      SIZE_HALF: size_nbytes = 3'd2;
      default:   size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_fill_cache_if.sv
// Request/response and main-memory port bundle for byte_fill_cache.
// slave = cache side, master = pipeline + memory side.
interface byte_fill_cache_if
  import byte_fill_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN        = DEF_LEN,
  parameter int BYTE_SIZE  = DEF_BYTE_SIZE
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_inst;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN-1:0]        req_wdata;
  logic                  resp_valid;
  logic [LEN-1:0]        resp_rdata;
  logic [BYTE_SIZE-1:0]  writen_data;
  logic [ADDR_WIDTH-1:0] mem_vis_addr;
  logic [1:0]            mem_vis_signal;
  logic [BYTE_SIZE-1:0]  mem_data;

  modport slave (
    input  req_valid, req_write, req_inst, req_size, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, writen_data, mem_vis_addr, mem_vis_signal
  );

  modport master (
    output req_valid, req_write, req_inst, req_size, req_addr, req_wdata, mem_data,
    input  req_ready, resp_valid, resp_rdata, writen_data, mem_vis_addr, mem_vis_signal
  );
endinterface

// File: rtl/byte_fill_cache_line_array.sv
// cache_line_array: per-line data bytes, tag and valid bit; combinational lookup,
// byte-enabled synchronous writes, valid bits cleared asynchronously by reset.
module cache_line_array
  import byte_fill_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int TAG_W        = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH,
  parameter int BYTE_SIZE    = DEF_BYTE_SIZE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [INDEX_WIDTH-1:0]                 index,
  input  logic [TAG_W-1:0]                       tag,
  output logic                                   hit,
  output logic [(2**OFFSET_WIDTH)*BYTE_SIZE-1:0] rd_line,
  input  logic [(2**OFFSET_WIDTH)-1:0]           wr_be,
  input  logic [(2**OFFSET_WIDTH)*BYTE_SIZE-1:0] wr_data,
  input  logic                                   tag_we
);
  localparam int LINES      = 2**INDEX_WIDTH;
  localparam int LINE_BYTES = 2**OFFSET_WIDTH;

  logic [LINE_BYTES*BYTE_SIZE-1:0] data_q [LINES];
  logic [TAG_W-1:0]                tag_q  [LINES];
  logic [LINES-1:0]                valid_q;

  assign hit     = valid_q[index] && (tag_q[index] == tag);
  assign rd_line = data_q[index];

  always_ff @(posedge clk) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wr_be[b]) data_q[index][b*BYTE_SIZE +: BYTE_SIZE] <= wr_data[b*BYTE_SIZE +: BYTE_SIZE];
    end
    if (tag_we) tag_q[index] <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      valid_q        <= '0;
    else if (tag_we) valid_q[index] <= 1'b1;
  end
endmodule

// File: rtl/byte_fill_cache.sv
// Direct-mapped write-through, no-write-allocate cache with byte-serial refill
// and write-through. Optional hit/miss counters when CACHE_STATS_EN is defined.
module byte_fill_cache
  import byte_fill_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LEN          = DEF_LEN,
  parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  byte_fill_cache_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  // state    | meaning
  // S_IDLE   | ready; lookup and accept a request
  // S_REFILL | cnt 0..15 read line bytes, 1..16 capture, 16 installs tag
  // S_WRITE  | write one store byte per cycle to memory
  // S_RESP   | one-cycle resp_valid pulse
  localparam int TAG_W      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_BYTES = 2**OFFSET_WIDTH;
  localparam int LINE_BITS  = LINE_BYTES * BYTE_SIZE;
  localparam int WORD_BYTES = LEN / BYTE_SIZE;
  localparam int CNT_W      = OFFSET_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BYTES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inst_q, inst_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [LEN-1:0]        rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] req_aligned, lk_addr;
  logic [2:0]            req_nbytes;
  logic                  hit, tag_we;
  logic [LINE_BITS-1:0]  rd_line, line_mrg, wr_data;
  logic [LINE_BYTES-1:0] wr_be;
  logic [OFFSET_WIDTH-1:0] fill_idx;

  function automatic logic [OFFSET_WIDTH-1:0] byte_pos(input logic [OFFSET_WIDTH-1:0] off,
                                                       input int i);
    byte_pos = off + OFFSET_WIDTH'(i);
  endfunction

  function automatic logic [LEN-1:0] pick(input logic [LINE_BITS-1:0] line,
                                          input logic [OFFSET_WIDTH-1:0] off,
                                          input logic [2:0] n);
    pick = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (3'(i) < n) pick[i*BYTE_SIZE +: BYTE_SIZE] = line[byte_pos(off, i)*BYTE_SIZE +: BYTE_SIZE];
    end
  endfunction

  always_comb begin
    req_aligned = bus.req_addr;
    case (bus.req_size)
      SIZE_BYTE: ;
      SIZE_HALF: req_aligned[0]   = 1'b0;
      default:   req_aligned[1:0] = 2'b00;
    endcase
  end

  assign req_nbytes = size_nbytes(bus.req_size);
  assign lk_addr    = (state_q == S_IDLE) ? req_aligned : addr_q;
  assign fill_idx   = cnt_q[OFFSET_WIDTH-1:0] - 1'b1;

  // The last refill byte arrives in the same cycle the response is built.
  always_comb begin
    line_mrg = rd_line;
    line_mrg[LINE_BITS-1 -: BYTE_SIZE] = bus.mem_data;
  end

  cache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_W       (TAG_W),
    .BYTE_SIZE   (BYTE_SIZE)
  ) u_lines (
    .clk    (clk),
    .rst_n  (rst_n),
    .index  (lk_addr[OFFSET_WIDTH +: INDEX_WIDTH]),
    .tag    (lk_addr[ADDR_WIDTH-1 -: TAG_W]),
    .hit    (hit),
    .rd_line(rd_line),
    .wr_be  (wr_be),
    .wr_data(wr_data),
    .tag_we (tag_we)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    nbytes_d = nbytes_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_be    = '0;
    wr_data  = '0;
    tag_we   = 1'b0;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.mem_vis_signal = MEM_IDLE;
    bus.mem_vis_addr   = '0;
    bus.writen_data    = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d   = req_aligned;
          inst_d   = bus.req_inst;
          nbytes_d = req_nbytes;
          wdata_d  = bus.req_wdata;
          cnt_d    = '0;
          if (bus.req_write) begin
            rdata_d = '0;
            state_d = S_WRITE;
            if (hit) begin
              for (int i = 0; i < WORD_BYTES; i++) begin
                if (3'(i) < req_nbytes) begin
                  wr_be[byte_pos(req_aligned[OFFSET_WIDTH-1:0], i)] = 1'b1;
                  wr_data[byte_pos(req_aligned[OFFSET_WIDTH-1:0], i)*BYTE_SIZE +: BYTE_SIZE] =
                    bus.req_wdata[i*BYTE_SIZE +: BYTE_SIZE];
                end
              end
            end
          end else if (hit) begin
            rdata_d = pick(rd_line, req_aligned[OFFSET_WIDTH-1:0], req_nbytes);
            state_d = S_RESP;
          end else begin
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (cnt_q != CNT_LAST) begin
          bus.mem_vis_signal = inst_q ? READ_INST : READ_DATA;
          bus.mem_vis_addr   = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], cnt_q[OFFSET_WIDTH-1:0]};
        end
        if (cnt_q != '0) begin
          wr_be[fill_idx] = 1'b1;
          wr_data         = {LINE_BYTES{bus.mem_data}};
        end
        if (cnt_q == CNT_LAST) begin
          tag_we  = 1'b1;
          rdata_d = pick(line_mrg, addr_q[OFFSET_WIDTH-1:0], nbytes_q);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        bus.mem_vis_signal = WRITE;
        bus.mem_vis_addr   = addr_q + {{(ADDR_WIDTH-CNT_W){1'b0}}, cnt_q};
        bus.writen_data    = wdata_q[cnt_q[1:0]*BYTE_SIZE +: BYTE_SIZE];
        if (cnt_q[2:0] + 3'd1 == nbytes_q) state_d = S_RESP;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      inst_q   <= 1'b0;
      nbytes_q <= 3'd0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      nbytes_q <= nbytes_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_IDLE && bus.req_valid && !bus.req_write) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_byte_fill_cache.sv
// Directed self-checking bench for byte_fill_cache with a byte-wide memory model.
module tb_byte_fill_cache;
  import byte_fill_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  byte_fill_cache_if bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  byte_fill_cache dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Memory model: initial contents by formula, overlaid with written bytes.
  logic [7:0]      wmem [1<<17];
  logic            wset [1<<17];
  logic [7:0]      mem_rd_q = 8'h00;

  function automatic logic [7:0] init_val(input logic [16:0] a);
    init_val = (a[7:0] - 8'h10) + {a[9:8], 6'b0};
  endfunction

  function automatic logic [7:0] mem_val(input logic [16:0] a);
    mem_val = (wset[a] === 1'b1) ? wmem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_vis_signal == WRITE) begin
      wmem[bus.mem_vis_addr] <= bus.writen_data;
      wset[bus.mem_vis_addr] <= 1'b1;
    end
    if (bus.mem_vis_signal == READ_DATA || bus.mem_vis_signal == READ_INST)
      mem_rd_q <= mem_val(bus.mem_vis_addr);
  end
  assign bus.mem_data = mem_rd_q;

  // Cumulative port monitor.
  int          rd_data_n = 0, rd_inst_n = 0, wr_n = 0, seq_err = 0, resp_n = 0;
  logic [16:0] rd_log [256];
  logic [16:0] wr_addr_log [64];
  logic [7:0]  wr_data_log [64];
  logic        prev_rd = 1'b0;
  logic [16:0] prev_addr = '0;

  always @(negedge clk) begin
    logic is_rd;
    is_rd = (bus.mem_vis_signal == READ_DATA || bus.mem_vis_signal == READ_INST);
    if (is_rd) begin
      if (prev_rd ? (bus.mem_vis_addr != prev_addr + 17'd1) : (bus.mem_vis_addr[3:0] != 4'h0))
        seq_err++;
      rd_log[(rd_data_n + rd_inst_n) % 256] = bus.mem_vis_addr;
      if (bus.mem_vis_signal == READ_DATA) rd_data_n++;
      else                                 rd_inst_n++;
    end
    prev_rd   = is_rd;
    prev_addr = bus.mem_vis_addr;
    if (bus.mem_vis_signal == WRITE) begin
      wr_addr_log[wr_n % 64] = bus.mem_vis_addr;
      wr_data_log[wr_n % 64] = bus.writen_data;
      wr_n++;
    end
    if (bus.resp_valid) resp_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic inst, input logic [1:0] sz,
                        input logic [16:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_inst  = inst;
    bus.req_size  = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    chk("ready_at_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rd  = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        break;
      end
    end
    @(negedge clk);
    chk("ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int          lat, rd0, rdi0, wr0, seq0, resp0;
    logic [31:0] rd;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_inst = 1'b0;
    bus.req_size = SIZE_WORD; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",      {31'd0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata",      bus.resp_rdata,          32'd0);
    chk("rst_wdata",      {24'd0, bus.writen_data}, 32'd0);
    chk("rst_addr",       {15'd0, bus.mem_vis_addr}, 32'd0);
    chk("rst_signal",     {30'd0, bus.mem_vis_signal}, {30'd0, MEM_IDLE});
    rst_n = 1'b1;

    // Cold word load: full refill of line 0x10.
    rd0 = rd_data_n; seq0 = seq_err; wr0 = wr_n;
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("miss_lat",   lat, 32'd18);
    chk("miss_rdata", rd,  32'h03020100);
    chk("miss_reads", rd_data_n - rd0, 32'd16);
    chk("miss_first_addr", {15'd0, rd_log[rd0 % 256]}, 32'h10);
    chk("miss_last_addr",  {15'd0, rd_log[(rd0 + 15) % 256]}, 32'h1F);
    chk("miss_seq",   seq_err - seq0, 32'd0);
`ifdef CACHE_STATS_EN
    chk("stat_miss1", miss_count, 32'd1);
`endif

    // Same load hits with no memory traffic.
    rd0 = rd_data_n + rd_inst_n; wr0 = wr_n;
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("hit_lat",   lat, 32'd1);
    chk("hit_rdata", rd,  32'h03020100);
    chk("hit_no_mem", (rd_data_n + rd_inst_n - rd0) + (wr_n - wr0), 32'd0);
`ifdef CACHE_STATS_EN
    chk("stat_hit1", hit_count, 32'd1);
`endif

    // Half store on a resident line: write-through and line merge.
    wr0 = wr_n; rd0 = rd_data_n + rd_inst_n;
    do_req(1'b1, 1'b0, SIZE_HALF, 17'h00012, 32'h1234BEEF, lat, rd);
    chk("hst_lat",    lat, 32'd3);
    chk("hst_rdata",  rd,  32'd0);
    chk("hst_writes", wr_n - wr0, 32'd2);
    chk("hst_w0_addr", {15'd0, wr_addr_log[wr0 % 64]}, 32'h12);
    chk("hst_w0_data", {24'd0, wr_data_log[wr0 % 64]}, 32'hEF);
    chk("hst_w1_addr", {15'd0, wr_addr_log[(wr0 + 1) % 64]}, 32'h13);
    chk("hst_w1_data", {24'd0, wr_data_log[(wr0 + 1) % 64]}, 32'hBE);
    chk("hst_no_reads", rd_data_n + rd_inst_n - rd0, 32'd0);
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("merge_lat",   lat, 32'd1);
    chk("merge_rdata", rd,  32'hBEEF0100);

    // Byte store to a non-resident line: no allocate.
    wr0 = wr_n; rd0 = rd_data_n + rd_inst_n;
    do_req(1'b1, 1'b0, SIZE_BYTE, 17'h00200, 32'hFFFFFF5A, lat, rd);
    chk("bst_lat",    lat, 32'd2);
    chk("bst_writes", wr_n - wr0, 32'd1);
    chk("bst_addr",   {15'd0, wr_addr_log[wr0 % 64]}, 32'h200);
    chk("bst_data",   {24'd0, wr_data_log[wr0 % 64]}, 32'h5A);
    chk("bst_no_refill", rd_data_n + rd_inst_n - rd0, 32'd0);
    do_req(1'b0, 1'b0, SIZE_BYTE, 17'h00200, 32'h0, lat, rd);
    chk("bld_lat",   lat, 32'd18);
    chk("bld_rdata", rd,  32'h0000005A);

    // Conflicting tags at index 1 after clearing the array.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd0 = rd_data_n;
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("cf0_lat",   lat, 32'd18);
    chk("cf0_rdata", rd,  32'hBEEF0100);
    chk("cf0_reads", rd_data_n - rd0, 32'd16);
    rd0 = rd_data_n; rdi0 = rd_inst_n; seq0 = seq_err;
    do_req(1'b0, 1'b1, SIZE_WORD, 17'h00110, 32'h0, lat, rd);
    chk("cf1_lat",   lat, 32'd18);
    chk("cf1_rdata", rd,  32'h43424140);
    chk("cf1_inst_reads", rd_inst_n - rdi0, 32'd16);
    chk("cf1_data_reads", rd_data_n - rd0, 32'd0);
    chk("cf1_first_addr", {15'd0, rd_log[(rd0 + rdi0) % 256]}, 32'h110);
    chk("cf1_seq", seq_err - seq0, 32'd0);
    rd0 = rd_data_n;
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("cf2_lat",   lat, 32'd18);
    chk("cf2_rdata", rd,  32'hBEEF0100);
    chk("cf2_reads", rd_data_n - rd0, 32'd16);

    // Reset during refill cycle 5, then reissue.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_inst = 1'b0;
    bus.req_size = SIZE_WORD; bus.req_addr = 17'h00010;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    resp0 = resp_n;
    rst_n = 1'b0;
    #1;
    chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("abort_signal", {30'd0, bus.mem_vis_signal}, {30'd0, MEM_IDLE});
    chk("abort_ready",  {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_resp", resp_n - resp0, 32'd0);
    do_req(1'b0, 1'b0, SIZE_WORD, 17'h00010, 32'h0, lat, rd);
    chk("reissue_lat",   lat, 32'd18);
    chk("reissue_rdata", rd,  32'hBEEF0100);

    // Half load at an odd address aligns down to 0x16.
    do_req(1'b0, 1'b0, SIZE_HALF, 17'h00017, 32'h0, lat, rd);
    chk("half_lat",   lat, 32'd1);
    chk("half_rdata", rd,  32'h00000706);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
